cv32e40x_xif_result_buffer: RTL
===============================

# cv32e40x_xif_result_buffer

In-order result buffer between the AES32 coprocessor result output and the core-side eXtension-interface result channel. It accepts {id, rd, data} results whenever it has space, so the AES unit can retire a result and take a new instruction while the core holds `result_ready` low. It drops results whose instruction is killed on the commit interface before they reach the core. It is a circular FIFO with per-entry live bits and registered outputs.

## Interface

Parameters:
- `DEPTH`, 2: entry count. Power of two, ≥2.
- `X_ID_WIDTH`, 4: instruction ID width.
- `X_RFW_WIDTH`, 32: result data width.

Ports:
- `clk_i`  in  1  clock. One clock domain; all logic is on the rising edge.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `in_valid_i`  in  1  upstream (AES) result valid.
- `in_ready_o`  out  1  buffer can accept.
- `in_id_i`  in  X_ID_WIDTH  instruction ID.
- `in_rd_i`  in  5  destination register.
- `in_data_i`  in  X_RFW_WIDTH  result value.
- `kill_valid_i`  in  1  commit-kill strobe: `commit_valid && commit_kill`.
- `kill_id_i`  in  X_ID_WIDTH  ID being killed.
- `result_valid_o`  out  1  head result valid toward core.
- `result_ready_i`  in  1  core accepts result.
- `result_id_o`  out  X_ID_WIDTH  head ID.
- `result_rd_o`  out  5  head rd.
- `result_data_o`  out  X_RFW_WIDTH  head data.
- `result_we_o`  out  1  register write enable; equals `result_valid_o`.
- `count_o`  out  $clog2(DEPTH)+1  occupied entries, squashed entries included.

## Operation

- Storage: DEPTH entries of {live, id, rd, data}. Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `count` is a separate register.
- Push: happens when `in_valid_i && in_ready_o`. Write to `wr_ptr` and increment it. `live = !(kill_valid_i && kill_id_i == in_id_i)`.
- `in_ready_o = (count < DEPTH)`. It does not depend on `result_ready_i`: when full, there is no push in the same cycle as a pop.
- Head presentation: `result_valid_o = (count != 0) && entry[rd_ptr].live`. The `result_*` outputs are driven from entry[rd_ptr] and are don't-care when valid is low. The bench checks them only when valid is high.
- Pop: a pop occurs when either
  - `result_valid_o && result_ready_i` (delivered), or
  - `count != 0 && !entry[rd_ptr].live` (squash drain: no valid is asserted, one entry per cycle).
- Kill: every occupied entry whose id matches `kill_id_i` has `live` cleared, except:
  - an entry being delivered in the same cycle completes delivery;
  - an entry being drained is unaffected.
- Count: `count_next = count + push - pop`. Width is $clog2(DEPTH)+1, and it never exceeds DEPTH.
- Reset, including mid-operation: `count = 0`, `wr_ptr = rd_ptr = 0`, all `live = 0`. Stored id/rd/data are not reset. Any in-flight results are discarded.

## Timing

- Reset values: `result_valid_o = 0`, `result_we_o = 0`, `in_ready_o = 1`, `count_o = 0`.
- Latency: a result pushed in cycle N appears on `result_valid_o` in cycle N+1 if the buffer was empty. There is no combinational in→out path.
- `result_valid_o` stays high, with stable id/rd/data, until the handshake.
  - A kill of the head ID while valid is high and ready is low drops valid in the next cycle. This is permitted because the XIF core never kills an instruction whose result it is waiting to accept on the same ID.
- Empty: a push and no pop gives count 1. Pop with count 0 is impossible by construction.
- Full: `in_ready_o` is low for the cycle in which count == DEPTH. It rises the cycle after a pop.
- Simultaneous push and pop at 0 < count < DEPTH: count is unchanged and both pointers advance.
- Throughput: one result per cycle sustained when `result_ready_i` is high, since count stays ≤ 1.

## Test plan

- Reset then single result: assert `rst_i` for 2 cycles and check all outputs at reset values. Push id=3, rd=5, data=0xDEADBEEF with `result_ready_i=1` → the next cycle shows valid=1 with those values. After the handshake, count=0.
- Backpressure to full, DEPTH=2: hold `result_ready_i=0` and push ids 1 and 2 → `in_ready_o=0` and count=2. A third `in_valid_i` is not accepted. Raise ready → id 1 then id 2 are delivered in consecutive cycles and `in_ready_o` returns to 1.
- Kill queued non-head entry: with ready=0, push ids 4 and 5, then kill id 5 → raise ready: only id 4 is delivered. The squashed entry drains in the following cycle with valid=0, and count reaches 0.
- Kill same cycle as push: push id 7 with `kill_id_i=7` → valid never rises and count goes 1 then 0.
- Kill during head handshake: head id 2 is valid with ready=1, and kill id 2 arrives in the same cycle → the transfer completes with data intact and count decrements once.
- Reset mid-operation with count=2 → the next cycle shows count=0 and valid=0, and a following push of id 9 is delivered normally.

Source files
------------

// File: rtl/cv32e40x_xif_result_buffer.sv
// In-order result buffer between the AES32 coprocessor and the XIF result channel.
// Circular FIFO with per-entry live bits; killed entries drain silently without asserting valid.
module cv32e40x_xif_result_buffer #(
    parameter int DEPTH       = 2,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [X_ID_WIDTH-1:0]      in_id_i,
    input  logic [4:0]                 in_rd_i,
    input  logic [X_RFW_WIDTH-1:0]     in_data_i,

    input  logic                       kill_valid_i,
    input  logic [X_ID_WIDTH-1:0]      kill_id_i,

    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [X_ID_WIDTH-1:0]      result_id_o,
    output logic [4:0]                 result_rd_o,
    output logic [X_RFW_WIDTH-1:0]     result_data_o,
    output logic                       result_we_o,

    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]       live_q;
    logic [DEPTH-1:0]       live_d;
    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
    logic [4:0]             rd_q   [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic head_live;
    logic not_empty;
    logic push;
    logic pop;

    assign not_empty  = (count_q != '0);
    assign head_live  = live_q[rd_ptr_q];
    assign in_ready_o = (count_q < CW'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    // A dead head is popped regardless of result_ready_i so squashed entries never stall the queue.
    assign pop        = not_empty && (!head_live || result_ready_i);
    assign count_d    = count_q + CW'(push) - CW'(pop);

    assign result_valid_o = not_empty && head_live;
    assign result_we_o    = result_valid_o;
    assign result_id_o    = id_q[rd_ptr_q];
    assign result_rd_o    = rd_q[rd_ptr_q];
    assign result_data_o  = data_q[rd_ptr_q];
    assign count_o        = count_q;

    // Unoccupied entries already hold live=0, so the kill can be applied to every slot;
    // a popped head is cleared anyway, which lets a same-cycle delivery complete untouched.
    always_comb begin
        live_d = live_q;
        if (kill_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (id_q[i] == kill_id_i) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = !(kill_valid_i && (kill_id_i == in_id_i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= '0;
        end else begin
            count_q <= count_d;
            live_q  <= live_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[wr_ptr_q]   <= in_id_i;
            rd_q[wr_ptr_q]   <= in_rd_i;
            data_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule
